// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared arbitration mode type for the stream mux
package mux_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational fixed-priority / round-robin request picker
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int        N    = 4,
   parameter arb_mode_e MODE = ARB_RR,
   localparam int       IW   = $clog2(N)
)(
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   always_comb begin : p_scan
      int w_start;
      int w_c;
      w_start   = 0;
      w_c       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      // Fixed mode always scans from channel 0; round-robin starts at ptr.
      if (MODE == ARB_RR) begin
         w_start = int'(ptr);
      end
      for (int k = 0; k < N; k++) begin
         w_c = w_start + k;
         if (w_c >= N) begin
            w_c = w_c - N;
         end
         if (!grant_any && request[w_c]) begin
            grant_any  = 1'b1;
            grant_idx  = IW'(w_c);
            grant[w_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-to-1 packet-locked stream mux with registered output stage
module stream_mux_arb
   import mux_pkg::*;
#(
   parameter int        WIDTH = 4,
   parameter int        N     = 4,
   parameter arb_mode_e MODE  = ARB_RR,
   localparam int       IW    = $clog2(N)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0]            in_valid,
   input  logic [N-1:0][WIDTH-1:0] in_data,
   input  logic [N-1:0]            in_last,
   output logic [N-1:0]            in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [IW-1:0]           out_chan,
   input  logic                    out_ready
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic [IW-1:0]    r_out_chan;
   logic [IW-1:0]    r_ptr;
   logic             r_lock;
   logic [IW-1:0]    r_lock_chan;

   logic             w_load_en;
   logic [N-1:0]     w_arb_grant;
   logic [IW-1:0]    w_arb_idx;
   logic             w_arb_any;
   logic [IW-1:0]    w_grant;
   logic             w_grant_valid;
   logic [N-1:0]     w_onehot;
   logic             w_accept;
   logic             w_last;

   rr_arbiter #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .request   (in_valid),
      .ptr       (r_ptr),
      .grant     (w_arb_grant),
      .grant_idx (w_arb_idx),
      .grant_any (w_arb_any)
   );

   // A locked packet owns the output regardless of what the arbiter would pick.
   assign w_load_en     = !r_out_valid || out_ready;
   assign w_grant       = r_lock ? r_lock_chan : w_arb_idx;
   assign w_grant_valid = r_lock ? in_valid[r_lock_chan] : w_arb_any;
   assign w_onehot      = r_lock ? (N'(1) << r_lock_chan) : w_arb_grant;
   assign w_accept      = rst_n && w_load_en && w_grant_valid;
   assign w_last        = in_last[w_grant];
   assign in_ready      = w_accept ? w_onehot : '0;

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_chan  = r_out_chan;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_chan  <= '0;
      end else if (w_load_en) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_data <= in_data[w_grant];
            r_out_last <= w_last;
            r_out_chan <= w_grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_accept && w_last) begin
         r_ptr <= (w_grant == IW'(N - 1)) ? '0 : w_grant + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock      <= 1'b0;
         r_lock_chan <= '0;
      end else if (w_accept) begin
         r_lock      <= !w_last;
         r_lock_chan <= w_grant;
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - bench for stream_mux_arb, round-robin and fixed instances side by side
module tb_stream_mux_arb;
   import mux_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       in_valid;
   logic [3:0][7:0]  in_data;
   logic [3:0]       in_last;
   logic             out_ready;
   logic [3:0]       rdy [2];
   logic             ov  [2];
   logic [7:0]       od  [2];
   logic             ol  [2];
   logic [1:0]       oc  [2];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   stream_mux_arb #(.WIDTH(8), .N(4), .MODE(ARB_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
      .out_chan(oc[0]), .out_ready(out_ready)
   );

   stream_mux_arb #(.WIDTH(8), .N(4), .MODE(ARB_FIXED)) u_fix (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
      .out_chan(oc[1]), .out_ready(out_ready)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference state per instance: index 0 is round-robin, index 1 is fixed priority.
   int m_ptr [2];
   int m_lock_ch [2];
   bit m_lock [2];
   bit m_ov [2];
   bit m_ol [2];
   int m_od [2];
   int m_oc [2];

   function automatic int pick(input int d, input logic [3:0] v);
      int start;
      if (m_lock[d]) return v[m_lock_ch[d]] ? m_lock_ch[d] : -1;
      start = (d == 1) ? 0 : m_ptr[d];
      for (int k = 0; k < 4; k++) begin
         if (v[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int         g;
         bit         load;
         logic [3:0] er;
         if (!rst_n) begin
            m_ptr[d] = 0; m_lock[d] = 0; m_lock_ch[d] = 0;
            m_ov[d] = 0; m_ol[d] = 0; m_od[d] = 0; m_oc[d] = 0;
         end
         load = !m_ov[d] || out_ready;
         g    = pick(d, in_valid);
         er   = (rst_n && load && g >= 0) ? 4'(1 << g) : 4'b0;
         check($sformatf("m%0d in_ready", d), int'(rdy[d]), int'(er));
         check($sformatf("m%0d out_valid", d), int'(ov[d]), int'(m_ov[d]));
         check($sformatf("m%0d out_data", d), int'(od[d]), m_od[d]);
         check($sformatf("m%0d out_last", d), int'(ol[d]), int'(m_ol[d]));
         check($sformatf("m%0d out_chan", d), int'(oc[d]), m_oc[d]);
         if (rst_n) begin
            if (er != 4'b0) begin
               m_ov[d] = 1;
               m_od[d] = int'(in_data[g]);
               m_ol[d] = in_last[g];
               m_oc[d] = g;
               if (in_last[g]) begin
                  m_lock[d] = 0;
                  m_ptr[d]  = (g + 1) % 4;
               end else begin
                  m_lock[d]    = 1;
                  m_lock_ch[d] = g;
               end
            end else if (load) begin
               m_ov[d] = 0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         exp_seq [5] = '{0, 1, 2, 3, 0};
      int         exp_c39 [4] = '{2, 2, 2, 0};
      int         exp_d39 [4] = '{8'h11, 8'h22, 8'h33, 8'h0C};
      int         got_c [4];
      int         got_d [4];
      logic [7:0] tbl [3];
      int         n;
      int         t;
      int         b;
      logic [3:0] fire;

      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      repeat (2) cyc();
      @(negedge clk);
      check("reset out_valid", int'(ov[0]), 0);
      check("reset in_ready", int'(rdy[0]), 0);
      check("reset out_data", int'(od[0]), 0);
      check("reset out_chan", int'(oc[0]), 0);
      cyc();
      rst_n = 1'b1;

      // Four single-beat channels rotate in round-robin order.
      in_valid = 4'hF; in_last = 4'hF; in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         @(negedge clk);
         check("rr rotate chan", int'(oc[0]), exp_seq[i]);
         check("rr rotate data", int'(od[0]), 8'hA0 + exp_seq[i]);
         check("fixed chan0 wins", int'(oc[1]), 0);
      end

      cyc();
      in_valid = 4'b1010; in_last = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fixed in_ready ch1 only", int'(rdy[1]), 4'b0010);
         if (i > 0) check("fixed out_chan", int'(oc[1]), 1);
         cyc();
      end

      // Channel 1 single beat moves ptr to 2, then ch2 packet must beat ch0.
      in_valid = 4'b0010; in_last = 4'b0010;
      cyc();
      tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33;
      in_valid = 4'b0101; in_last = 4'b0001;
      in_data[2] = 8'h11; in_data[0] = 8'h0C;
      n = 0; t = 0; b = 0;
      while (n < 4 && t < 20) begin
         @(negedge clk);
         fire = rdy[0] & in_valid;
         cyc();
         t++;
         if (fire != 4'b0) begin
            got_c[n] = int'(oc[0]);
            got_d[n] = int'(od[0]);
            n++;
         end
         if (fire[2]) begin
            b++;
            if (b == 3) in_valid[2] = 1'b0;
            else begin
               in_data[2] = tbl[b];
               in_last[2] = (b == 2);
            end
         end
         if (fire[0]) in_valid[0] = 1'b0;
      end
      if (n < 4) check("pkt beats seen", n, 4);
      for (int i = 0; i < 4; i++) begin
         check("pkt chan order", (i < n) ? got_c[i] : -1, exp_c39[i]);
         check("pkt data order", (i < n) ? got_d[i] : -1, exp_d39[i]);
      end

      // Backpressure: held beat and zero in_ready while out_ready is low.
      in_valid = 4'b0; out_ready = 1'b1;
      cyc();
      in_valid = 4'b0001; in_last = 4'hF; in_data[0] = 8'h5A; out_ready = 1'b0;
      cyc();
      in_valid = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall out_data", int'(od[0]), 8'h5A);
         check("stall out_valid", int'(ov[0]), 1);
         check("stall in_ready", int'(rdy[0]), 0);
         cyc();
         in_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("resume out_valid", int'(ov[0]), 1);
         check("resume in_ready nonzero", int'(rdy[0] != 4'b0), 1);
         cyc();
      end

      // Lock on ch1, then ch1 pauses while ch0 waits.
      in_valid = 4'b0010; in_last = 4'b0000;
      cyc();
      in_valid = 4'b0001; in_last = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("locked in_ready", int'(rdy[0]), 0);
         if (i == 1) check("locked out_valid", int'(ov[0]), 0);
         cyc();
      end
      in_valid = 4'b0011; in_last = 4'b0011;
      @(negedge clk);
      check("lock resume in_ready", int'(rdy[0]), 4'b0010);
      cyc();
      @(negedge clk);
      check("lock resume chan", int'(oc[0]), 1);

      // Asynchronous reset mid-transfer, then arbitration restarts at ptr 0.
      cyc();
      in_valid = 4'hF; in_last = 4'b1011; out_ready = 1'b1;
      repeat (2) cyc();
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid rr", int'(ov[0]), 0);
      check("async rst out_valid fix", int'(ov[1]), 0);
      check("async rst in_ready rr", int'(rdy[0]), 0);
      check("async rst in_ready fix", int'(rdy[1]), 0);
      @(negedge clk);
      cyc();
      rst_n = 1'b1;
      in_last = 4'hF;
      @(negedge clk);
      check("post rst in_ready", int'(rdy[0]), 4'b0001);
      cyc();
      @(negedge clk);
      check("post rst chan", int'(oc[0]), 0);
      check("post rst valid", int'(ov[0]), 1);

      cyc();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 4'($urandom);
         for (int c = 0; c < 4; c++) in_last[c] = ($urandom_range(0, 2) == 0);
         in_data   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stream_mux_arb.md
STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 Parameter: WIDTH, default 4, data width per channel in bits.
REQ-002 Parameter: N, default 4, input channel count; legal range 2..16.
REQ-003 Parameter: MODE, default ARB_RR, arbitration mode (ARB_FIXED or ARB_RR).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  N  per-channel beat valid.
REQ-007 Port: in_data  input  N x WIDTH  per-channel beat data.
REQ-008 Port: in_last  input  N  per-channel last beat of packet.
REQ-009 Port: in_ready  output  N  per-channel accept; one-hot or zero.
REQ-010 Port: out_valid  output  1  registered beat valid.
REQ-011 Port: out_data  output  WIDTH  registered beat data.
REQ-012 Port: out_last  output  1  registered last flag.
REQ-013 Port: out_chan  output  $clog2(N)  index of the source channel of the current output beat.
REQ-014 Port: out_ready  input  1  downstream accept.

Function
REQ-015 A transfer occurs on a port when valid and ready are both 1 at a rising clk edge.
REQ-016 Output stage: one-entry register; load_en = !out_valid || out_ready.
REQ-017 in_ready[g] = load_en && in_valid[g] && (g == grant); all other in_ready bits are 0.
REQ-018 Latency: a beat accepted at edge k appears on out_* in the cycle after edge k; full throughput of 1 beat/cycle while out_ready = 1.
REQ-019 If out_valid && !out_ready: out_* hold stable and in_ready is all zero.
REQ-020 If load_en and no input is valid: out_valid goes to 0 at the next edge; out_data, out_last and out_chan hold their values.
REQ-021 ARB_FIXED: grant is the lowest-index valid channel.
REQ-022 ARB_RR: grant is the first valid channel scanning ptr, ptr+1, ... modulo N.
REQ-023 ARB_RR pointer: after an accepted beat with in_last = 1 from channel g, ptr <= (g+1) mod N, wrapping from N-1 to 0; otherwise ptr holds.
REQ-024 Packet lock: an accepted beat with in_last = 0 sets lock = 1 and lock_chan = g; an accepted beat with in_last = 1 clears lock.
REQ-025 While lock = 1, grant = lock_chan regardless of other channels' valid bits or MODE; other channels stall.
REQ-026 While locked, if in_valid[lock_chan] = 0, no beat is accepted and the lock is held.
REQ-027 A single-beat packet (in_last = 1 on the first beat) never sets the lock.
REQ-028 Inputs not granted have no effect on state; X on non-granted in_data must not propagate to out_data.
REQ-029 The output never changes when only the input data changes while out_valid && !out_ready.

Reset
REQ-030 While rst_n = 0, asynchronously: out_valid = 0, out_data = 0, out_last = 0, out_chan = 0, ptr = 0, lock = 0, lock_chan = 0.
REQ-031 Reset mid-packet discards the held beat and the lock; after release, arbitration restarts from ptr = 0.
REQ-032 in_ready is all zero while rst_n = 0.

Structure
REQ-033 Shared package mux_pkg holds the enum arb_mode_e {ARB_FIXED, ARB_RR}; the module imports it.
REQ-034 Sub-module rr_arbiter (N, MODE, request, ptr -> one-hot grant and grant index) is purely combinational and instantiated once.
REQ-035 Total RTL is 120-400 lines; the block contains no latches and has one always_ff process per register group.

Verification (N=4, WIDTH=8, MODE=ARB_RR unless stated)
REQ-036 Reset: assert rst_n = 0 mid-transfer -> out_valid = 0 and in_ready = 0000 immediately, with no clock edge required.
REQ-037 All four channels valid with single-beat packets, data 8'hA0+i, out_ready = 1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-038 ARB_FIXED, channels 1 and 3 continuously valid -> channel 1 wins every cycle; in_ready[3] stays 0.
REQ-039 Channel 2 sends a 3-beat packet (8'h11, 8'h22, 8'h33) while channel 0 is valid -> channel 2 is accepted three times, then channel 0 (ptr = 3 wraps to 0).
REQ-040 out_ready = 0 for 3 cycles with out_data = 8'h5A -> out_data stays 8'h5A and in_ready = 0000; out_ready = 1 then resumes at 1 beat/cycle.
REQ-041 Locked on channel 1, channel 1 drops valid for 2 cycles while channel 0 is valid -> no transfer occurs until channel 1 resumes.
